// File: rtl/fpu_fcvt_w_seq.sv
// fpu_fcvt_w_seq: iterative FCVT.W.S / FCVT.WU.S (round toward zero).
// Shifts the significand one bit per cycle into integer position, then negates if needed.
// Optional macro FCVT_FLAGS_EN: when defined, drives fflags {nv, nx} and tracks sticky bits;
// when undefined, fflags is tied to zero and the sticky logic is absent.
`timescale 1ns/1ps
module fpu_fcvt_w_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic        is_unsigned,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  fflags
);

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e      state_q;
    logic        sign_q;
    logic        special_q;
    logic        left_q;
    logic [31:0] acc_q;
    logic [31:0] spec_res_q;
    logic [4:0]  cnt_q;

    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic        cls_special;
    logic        cls_left;
    logic [4:0]  cls_cnt;
    logic [31:0] cls_res;

    assign in_exp  = rs1[30:23];
    assign in_frac = rs1[22:0];

    // Classify the incoming operand; is_unsigned only matters here, so it is not stored.
    always_comb begin
        cls_special = 1'b1;
        cls_res     = 32'h0000_0000;
        cls_left    = in_exp > 8'd150;
        cls_cnt     = cls_left ? 5'(in_exp - 8'd150) : 5'(8'd150 - in_exp);
        if (rs1[30:0] == 31'h0) begin
            cls_res = 32'h0000_0000;
        end else if (in_exp == 8'hFF && in_frac != 23'h0) begin
            cls_res = is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        end else if (in_exp < 8'd127) begin
            cls_res = 32'h0000_0000;
        end else if (is_unsigned) begin
            if (rs1[31]) begin
                cls_res = 32'h0000_0000;
            end else if (in_exp > 8'd158) begin
                cls_res = 32'hFFFF_FFFF;
            end else begin
                cls_special = 1'b0;
            end
        end else begin
            // -2^31 is the only representable value with e == 158.
            if (in_exp > 8'd158 || (in_exp == 8'd158 && !(rs1[31] && in_frac == 23'h0))) begin
                cls_res = rs1[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                cls_special = 1'b0;
            end
        end
    end

    // Main FSM: latch operand, shift one bit per cycle, then write back the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'h0000_0000;
            cnt_q      <= 5'd0;
            acc_q      <= 32'h0000_0000;
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            left_q     <= 1'b0;
            spec_res_q <= 32'h0000_0000;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sign_q     <= rs1[31];
                        acc_q      <= {8'h00, 1'b1, in_frac};
                        special_q  <= cls_special;
                        spec_res_q <= cls_res;
                        left_q     <= cls_left;
                        cnt_q      <= cls_special ? 5'd0 : cls_cnt;
                        busy       <= 1'b1;
                        state_q    <= (cls_special || cls_cnt == 5'd0) ? StFinish : StShift;
                    end
                end
                StShift: begin
                    acc_q <= left_q ? (acc_q << 1) : (acc_q >> 1);
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    result  <= special_q ? spec_res_q : (sign_q ? -acc_q : acc_q);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FCVT_FLAGS_EN
    logic       sticky_q;
    logic [1:0] spec_flags_q;
    logic [1:0] cls_flags;

    // Specials: nx for nonzero values below 1.0, nv for every other nonzero special.
    always_comb begin
        cls_flags = 2'b00;
        if (rs1[30:0] != 31'h0) begin
            if (in_exp < 8'd127) begin
                cls_flags = 2'b01;
            end else begin
                cls_flags = {cls_special, 1'b0};
            end
        end
    end

    // Sticky collects bits dropped by right shifts; flags update together with result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q     <= 1'b0;
            spec_flags_q <= 2'b00;
            fflags       <= 2'b00;
        end else begin
            if (state_q == StIdle && start) begin
                sticky_q     <= 1'b0;
                spec_flags_q <= cls_flags;
            end else if (state_q == StShift && !left_q) begin
                sticky_q <= sticky_q | acc_q[0];
            end else if (state_q == StFinish) begin
                fflags <= special_q ? spec_flags_q : {1'b0, sticky_q};
            end
        end
    end
`else
    assign fflags = 2'b00;
`endif

endmodule

// File: tb/tb_fpu_fcvt_w_seq.sv
// Bench for fpu_fcvt_w_seq: directed operands plus randomized ones, checked every cycle
// against an arithmetic model of float-to-int truncation.
`timescale 1ns/1ps
module tb_fpu_fcvt_w_seq;

`ifdef FCVT_FLAGS_EN
    localparam bit FlagsOn = 1'b1;
`else
    localparam bit FlagsOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] rs1 = 32'h0;
    logic        is_unsigned = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  fflags;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          t_issue;
        int          t_due;
        logic [31:0] res;
        logic [1:0]  fl;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_res = 32'h0;
    logic [1:0]  last_fl = 2'b00;
    logic        due_now;
    logic        exp_busy;

    fpu_fcvt_w_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rs1         (rs1),
        .is_unsigned (is_unsigned),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .fflags      (fflags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Reference: exact value, truncated toward zero, then range-checked.
    function automatic void model(input logic [31:0] x, input bit uns,
                                  output logic [31:0] res, output logic [1:0] fl,
                                  output int n);
        int     e = int'(x[30:23]);
        bit     s = x[31];
        longint mag = longint'({1'b1, x[22:0]});
        longint v;
        longint dv;
        longint lo = uns ? 64'sd0 : -64'sd2147483648;
        longint hi = uns ? 64'sd4294967295 : 64'sd2147483647;
        bit     inex = 1'b0;
        res = 32'h0;
        fl  = 2'b00;
        n   = 0;
        if (x[30:0] == 31'h0) return;
        if (e == 255 && x[22:0] != 23'h0) begin
            res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            fl  = 2'b10;
            return;
        end
        if (e < 127) begin
            fl = 2'b01;
            return;
        end
        if (e >= 160) begin
            v = longint'(1) <<< 40;
        end else if (e >= 150) begin
            v = mag <<< (e - 150);
        end else begin
            dv   = longint'(1) <<< (150 - e);
            v    = mag / dv;
            inex = (mag % dv) != 0;
        end
        if (s) v = -v;
        if (v < lo || v > hi) begin
            res = s ? (uns ? 32'h0000_0000 : 32'h8000_0000) : (uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
            fl  = 2'b10;
            return;
        end
        res = 32'(v);
        fl  = {1'b0, inex};
        n   = (e > 150) ? e - 150 : 150 - e;
    endfunction

    // Per-cycle compare of busy/done/result/fflags against the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            due_now  = exp_q.size() > 0 && exp_q[0].t_due == cyc;
            exp_busy = exp_q.size() > 0 && cyc > exp_q[0].t_issue && cyc < exp_q[0].t_due;
            chk("busy", {31'h0, busy}, {31'h0, exp_busy});
            chk("done", {31'h0, done}, {31'h0, due_now});
            if (due_now) begin
                last_res = exp_q[0].res;
                last_fl  = exp_q[0].fl;
                void'(exp_q.pop_front());
            end
            chk("result", result, last_res);
            chk("fflags", {30'h0, fflags}, {30'h0, last_fl});
        end
    end

    // Called at posedge+2 with the DUT idle (or in its done cycle).
    task automatic issue(input logic [31:0] x, input bit uns);
        exp_t        t;
        logic [31:0] r;
        logic [1:0]  f;
        int          n;
        model(x, uns, r, f, n);
        start       = 1'b1;
        rs1         = x;
        is_unsigned = uns;
        t.t_issue   = cyc;
        t.t_due     = cyc + n + 2;
        t.res       = r;
        t.fl        = FlagsOn ? f : 2'b00;
        exp_q.push_back(t);
        @(posedge clk);
        #2;
        start = 1'b0;
        rs1   = $urandom;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            @(posedge clk);
            #2;
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout cyc=%0d got=pending want=done", cyc);
            exp_q.delete();
        end
    endtask

    task automatic wait_due();
        int d;
        if (exp_q.size() == 0) return;
        d = exp_q[0].t_due;
        while (cyc < d) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pin(input string name, input logic [31:0] x, input bit uns,
                       input logic [31:0] wr, input logic [1:0] wf, input int wn);
        logic [31:0] r;
        logic [1:0]  f;
        int          n;
        model(x, uns, r, f, n);
        chk({name, "_res"}, r, wr);
        chk({name, "_fl"}, {30'h0, f}, {30'h0, wf});
        chk({name, "_lat"}, 32'(n), 32'(wn));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] edges [8];
        logic [31:0] x;
        bit          u;
        int          c0;
        edges = '{8'd0, 8'd255, 8'd126, 8'd127, 8'd150, 8'd157, 8'd158, 8'd159};

        // Hand-computed anchors for the model.
        pin("p_3p75", 32'h4070_0000, 1'b0, 32'h0000_0003, 2'b01, 22);
        pin("p_m2e31s", 32'hCF00_0000, 1'b0, 32'h8000_0000, 2'b00, 8);
        pin("p_m2e31u", 32'hCF00_0000, 1'b1, 32'h0000_0000, 2'b10, 0);
        pin("p_3e9u", 32'h4F32_D05E, 1'b1, 32'hB2D0_5E00, 2'b00, 8);
        pin("p_3e9s", 32'h4F32_D05E, 1'b0, 32'h7FFF_FFFF, 2'b10, 0);
        pin("p_nan", 32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF, 2'b10, 0);
        pin("p_half", 32'h3F00_0000, 1'b0, 32'h0000_0000, 2'b01, 0);
        pin("p_mzero", 32'h8000_0000, 1'b0, 32'h0000_0000, 2'b00, 0);
        pin("p_one", 32'h3F80_0000, 1'b0, 32'h0000_0001, 2'b00, 23);
        pin("p_two", 32'h4000_0000, 1'b0, 32'h0000_0002, 2'b00, 22);
        pin("p_m1p5", 32'hBFC0_0000, 1'b0, 32'hFFFF_FFFF, 2'b01, 23);

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Directed operands from the plan.
        issue(32'h4070_0000, 1'b0); wait_idle();
        issue(32'hCF00_0000, 1'b0); wait_idle();
        issue(32'hCF00_0000, 1'b1); wait_idle();
        issue(32'h4F32_D05E, 1'b1); wait_idle();
        issue(32'h4F32_D05E, 1'b0); wait_idle();
        issue(32'h7FC0_0000, 1'b0); wait_idle();
        issue(32'h3F00_0000, 1'b0); wait_idle();
        issue(32'h8000_0000, 1'b0); wait_idle();

        // Start re-pulsed while busy is ignored; start in the done cycle is accepted.
        c0 = cyc;
        issue(32'h3F80_0000, 1'b0);
        while (cyc < c0 + 5) begin @(posedge clk); #2; end
        start = 1'b1; rs1 = 32'h4000_0000;
        @(posedge clk); #2;
        start = 1'b0;
        wait_due();
        chk("b2b_due", 32'(cyc - c0), 32'd25);
        issue(32'h4000_0000, 1'b0);
        wait_idle();

        // Reset in the middle of a shift aborts without a done pulse.
        c0 = cyc;
        issue(32'hBFC0_0000, 1'b0);
        while (cyc < c0 + 4) begin @(posedge clk); #2; end
        rst = 1'b1;
        exp_q.delete();
        last_res = 32'h0;
        last_fl  = 2'b00;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        @(posedge clk); #2;
        issue(32'hBFC0_0000, 1'b0); wait_idle();

        // Randomized operands, biased toward the interesting exponent band.
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            u = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                1, 2: x[30:23] = 8'($urandom_range(120, 165));
                3: x[30:23] = edges[$urandom_range(0, 7)];
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) x[22:0] = 23'h0;
            issue(x, u);
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1; rs1 = $urandom; is_unsigned = 1'($urandom_range(0, 1));
                @(posedge clk); #2;
                start = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) begin
                wait_due();
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
